// File: rtl/ber_pkg.sv
// Shared constants for the BER measurement sequencer.
// State encodings and default counter widths.
package ber_pkg;

  localparam int DEF_CW = 32;
  localparam int DEF_GW = 16;
  localparam int DEF_SW = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_FIN     = 2'd3;

endpackage

// File: rtl/ber_meas_ctrl_if.sv
// Control-plane and checker-side bundle for ber_meas_ctrl.
// master drives commands and bit stream, slave is the sequencer.
interface ber_meas_ctrl_if
  import ber_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int GW = DEF_GW,
  parameter int SW = DEF_SW
);

  logic          START;
  logic          STOP;
  logic          ABORT;
  logic [SW-1:0] SETTLE_LEN;
  logic [GW-1:0] GATE_LEN;
  logic          SYNC_OK;
  logic          BIT_VLD;
  logic          BIT_ERR;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] BIT_CNT;
  logic [CW-1:0] ERR_CNT;
  logic          CNT_SAT;
  logic          SYNC_LOST;

  modport master (
    output START, STOP, ABORT,
    output SETTLE_LEN, GATE_LEN,
    output SYNC_OK, BIT_VLD, BIT_ERR,
    input  BUSY, DONE,
    input  BIT_CNT, ERR_CNT,
    input  CNT_SAT, SYNC_LOST
  );

  modport slave (
    input  START, STOP, ABORT,
    input  SETTLE_LEN, GATE_LEN,
    input  SYNC_OK, BIT_VLD, BIT_ERR,
    output BUSY, DONE,
    output BIT_CNT, ERR_CNT,
    output CNT_SAT, SYNC_LOST
  );

endinterface

// File: rtl/ber_dcnt.sv
// Loadable down-counter that stops at zero.
// Used for the settle timer and the gate window.
module ber_dcnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] VAL,
  input  logic         DEC,
  output logic [W-1:0] CNT,
  output logic         ZERO
);

  assign ZERO = (CNT == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT <= '0;
    end else if (LOAD) begin
      CNT <= VAL;
    end else if (DEC && !ZERO) begin
      CNT <= CNT - W'(1);
    end
  end

endmodule

// File: rtl/ber_meas_ctrl.sv
// BER measurement sequencer: settle, lock wait, gated or
// free-running bit/error count, one-cycle DONE on completion.
module ber_meas_ctrl
  import ber_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int GW = DEF_GW,
  parameter int SW = DEF_SW
) (
  input logic           CLK,
  input logic           RST,
  ber_meas_ctrl_if.slave bus
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic          free_run;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] err_cnt;
  logic          sat_q;
  logic          lost_q;

  logic [SW-1:0] s_cnt;
  logic          s_zero;
  logic [GW-1:0] g_cnt;
  logic          g_zero;
  logic          unused_ok;

  logic start_ok;
  logic in_meas;
  logic cnt_bit;
  logic gate_last;

  assign start_ok = bus.START && !bus.ABORT &&
                    (state == ST_IDLE ||
                     state == ST_FIN);
  assign in_meas   = (state == ST_MEASURE) && !bus.ABORT;
  assign cnt_bit   = in_meas && bus.BIT_VLD;
  assign gate_last = cnt_bit && !free_run &&
                     (g_cnt == GW'(1));
  assign unused_ok = ^{s_cnt, g_zero};

  ber_dcnt #(.W(SW)) u_settle (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (start_ok),
    .VAL  (bus.SETTLE_LEN),
    .DEC  (state == ST_SETTLE),
    .CNT  (s_cnt),
    .ZERO (s_zero)
  );

  ber_dcnt #(.W(GW)) u_gate (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (start_ok),
    .VAL  (bus.GATE_LEN),
    .DEC  (cnt_bit && !free_run),
    .CNT  (g_cnt),
    .ZERO (g_zero)
  );

  always_comb begin
    nxt = state;
    if (bus.ABORT) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (bus.START) nxt = ST_SETTLE;
        ST_SETTLE:
          if (s_zero && bus.SYNC_OK)
            nxt = ST_MEASURE;
        ST_MEASURE:
          if (gate_last || bus.STOP)
            nxt = ST_FIN;
        ST_FIN:
          nxt = bus.START ? ST_SETTLE
                          : ST_IDLE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Counters saturate; a blocked increment marks CNT_SAT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      free_run <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      sat_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt == ST_SETTLE) ||
                (nxt == ST_MEASURE);
      done_q <= (nxt == ST_FIN);
      if (start_ok) begin
        free_run <= (bus.GATE_LEN == '0);
        bit_cnt  <= '0;
        err_cnt  <= '0;
        sat_q    <= 1'b0;
        lost_q   <= 1'b0;
      end else if (in_meas) begin
        if (!bus.SYNC_OK) lost_q <= 1'b1;
        if (bus.BIT_VLD) begin
          if (&bit_cnt) sat_q <= 1'b1;
          else bit_cnt <= bit_cnt + ONE;
          if (bus.BIT_ERR) begin
            if (&err_cnt) sat_q <= 1'b1;
            else err_cnt <= err_cnt + ONE;
          end
        end
      end
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.BIT_CNT   = bit_cnt;
  assign bus.ERR_CNT   = err_cnt;
  assign bus.CNT_SAT   = sat_q;
  assign bus.SYNC_LOST = lost_q;

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Directed bench for ber_meas_ctrl with a 4-bit result width
// so saturation is reachable in a short free-run.
module tb_ber_meas_ctrl;

  localparam int CW = 4;
  localparam int GW = 16;
  localparam int SW = 8;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  ber_meas_ctrl_if #(.CW(CW), .GW(GW), .SW(SW)) bus ();

  ber_meas_ctrl #(.CW(CW), .GW(GW), .SW(SW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // START pulse in cycle 0; returns in cycle 1 with the
  // length inputs scrambled to show they were latched.
  task automatic start_run(input logic [SW-1:0] s,
                           input logic [GW-1:0] g);
    bus.SETTLE_LEN = s;
    bus.GATE_LEN   = g;
    bus.START      = 1'b1;
    tick();
    bus.START      = 1'b0;
    bus.SETTLE_LEN = 8'h5a;
    bus.GATE_LEN   = 16'h0002;
  endtask

  initial begin
    int e;
    RST            = 1'b1;
    bus.START      = 1'b1;
    bus.STOP       = 1'b0;
    bus.ABORT      = 1'b0;
    bus.SETTLE_LEN = '0;
    bus.GATE_LEN   = '0;
    bus.SYNC_OK    = 1'b1;
    bus.BIT_VLD    = 1'b1;
    bus.BIT_ERR    = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_bits", bus.BIT_CNT, 0);
    chk("rst_errs", bus.ERR_CNT, 0);
    chk("rst_sat", bus.CNT_SAT, 0);
    chk("rst_lost", bus.SYNC_LOST, 0);
    RST       = 1'b0;
    bus.START = 1'b0;
    bus.BIT_ERR = 1'b0;
    tick();
    chk("idle_busy", bus.BUSY, 0);

    // 1: gated window, settle 3, 10 bits, 2 errors
    start_run(8'd3, 16'd10);
    for (int k = 1; k <= 16; k++) begin
      bus.BIT_ERR = (k == 7 || k == 10);
      e = (k <= 5) ? 0 : ((k >= 15) ? 10 : k - 5);
      chk("t1_busy", bus.BUSY, 32'(k <= 14));
      chk("t1_done", bus.DONE, 32'(k == 15));
      chk("t1_bits", bus.BIT_CNT, e);
      tick();
    end
    chk("t1_errs", bus.ERR_CNT, 2);
    chk("t1_sat", bus.CNT_SAT, 0);
    chk("t1_lost", bus.SYNC_LOST, 0);

    // 2: lock wait with settle 0
    bus.BIT_ERR = 1'b0;
    bus.SYNC_OK = 1'b0;
    start_run(8'd0, 16'd4);
    repeat (20) tick();
    chk("t2_wait_busy", bus.BUSY, 1);
    chk("t2_wait_bits", bus.BIT_CNT, 0);
    bus.SYNC_OK = 1'b1;
    tick();
    chk("t2_meas0_bits", bus.BIT_CNT, 0);
    tick();
    chk("t2_meas1_bits", bus.BIT_CNT, 1);
    chk("t2_meas1_done", bus.DONE, 0);
    repeat (3) tick();
    chk("t2_done", bus.DONE, 1);
    chk("t2_bits", bus.BIT_CNT, 4);
    chk("t2_lost", bus.SYNC_LOST, 0);
    tick();

    // 3: sparse valid bits, errors on invalid cycles ignored
    start_run(8'd0, 16'd4);
    for (int k = 1; k <= 13; k++) begin
      bus.BIT_VLD = (k == 1) || (k >= 2 && (k - 2) % 3 == 0);
      bus.BIT_ERR = k[0];
      chk("t3_done", bus.DONE, 32'(k == 12));
      tick();
    end
    chk("t3_bits", bus.BIT_CNT, 4);
    chk("t3_errs", bus.ERR_CNT, 2);

    // 4: free-run into saturation, STOP in settle ignored
    bus.BIT_VLD = 1'b0;
    bus.BIT_ERR = 1'b1;
    start_run(8'd5, 16'd0);
    bus.STOP = 1'b1;
    repeat (3) tick();
    bus.STOP = 1'b0;
    chk("t4_settle_busy", bus.BUSY, 1);
    chk("t4_settle_done", bus.DONE, 0);
    repeat (3) tick();
    bus.BIT_VLD = 1'b1;
    repeat (5) tick();
    chk("t4_mid_bits", bus.BIT_CNT, 5);
    repeat (15) tick();
    chk("t4_run_busy", bus.BUSY, 1);
    chk("t4_run_done", bus.DONE, 0);
    bus.BIT_VLD = 1'b0;
    bus.STOP    = 1'b1;
    tick();
    bus.STOP = 1'b0;
    chk("t4_done", bus.DONE, 1);
    chk("t4_busy", bus.BUSY, 0);
    chk("t4_bits", bus.BIT_CNT, 15);
    chk("t4_errs", bus.ERR_CNT, 15);
    chk("t4_sat", bus.CNT_SAT, 1);
    tick();
    chk("t4_done_pulse", bus.DONE, 0);

    // 5: ABORT beats START and STOP
    bus.BIT_VLD = 1'b1;
    bus.BIT_ERR = 1'b0;
    start_run(8'd0, 16'd10);
    repeat (7) tick();
    chk("t5_pre_bits", bus.BIT_CNT, 6);
    bus.ABORT = 1'b1;
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    chk("t5_abort_busy", bus.BUSY, 0);
    chk("t5_abort_done", bus.DONE, 0);
    chk("t5_abort_bits", bus.BIT_CNT, 6);
    tick();
    chk("t5_idle_done", bus.DONE, 0);
    chk("t5_idle_busy", bus.BUSY, 0);
    bus.BIT_ERR = 1'b1;
    start_run(8'd2, 16'd3);
    chk("t5_clr_bits", bus.BIT_CNT, 0);
    chk("t5_clr_sat", bus.CNT_SAT, 0);
    chk("t5_new_busy", bus.BUSY, 1);
    repeat (6) tick();
    chk("t5_new_done", bus.DONE, 1);
    chk("t5_new_bits", bus.BIT_CNT, 3);
    chk("t5_new_errs", bus.ERR_CNT, 3);
    tick();

    // 6: reset mid-measure after lock loss
    start_run(8'd1, 16'd8);
    repeat (4) tick();
    bus.SYNC_OK = 1'b0;
    tick();
    chk("t6_lost_pre", bus.SYNC_LOST, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.SYNC_OK = 1'b1;
    bus.BIT_ERR = 1'b0;
    chk("t6_rst_busy", bus.BUSY, 0);
    chk("t6_rst_done", bus.DONE, 0);
    chk("t6_rst_bits", bus.BIT_CNT, 0);
    chk("t6_rst_errs", bus.ERR_CNT, 0);
    chk("t6_rst_lost", bus.SYNC_LOST, 0);
    chk("t6_rst_sat", bus.CNT_SAT, 0);
    start_run(8'd0, 16'd5);
    tick();
    bus.SYNC_OK = 1'b0;
    tick();
    bus.SYNC_OK = 1'b1;
    bus.START   = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (3) tick();
    chk("t6_done", bus.DONE, 1);
    chk("t6_bits", bus.BIT_CNT, 5);
    chk("t6_lost", bus.SYNC_LOST, 1);

    // START in FIN restarts straight into settle
    bus.SYNC_OK = 1'b0;
    start_run(8'd0, 16'd2);
    chk("t6_fin_busy", bus.BUSY, 1);
    chk("t6_fin_done", bus.DONE, 0);
    chk("t6_fin_lost", bus.SYNC_LOST, 0);
    bus.SYNC_OK = 1'b1;
    repeat (3) tick();
    chk("t6_re_done", bus.DONE, 1);
    chk("t6_re_bits", bus.BIT_CNT, 2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_meas_ctrl.md
Name: ber_meas_ctrl

Overview:
Measurement sequencer for the BER checker.
- After START, waits a programmable settle time and for pattern lock.
- Then counts compared bits and bit errors over a gate window of GATE_LEN valid bits, or free-runs until STOP.
- Reports results with a one-cycle DONE pulse.
- Sits between the register/UART control plane and the pattern checker's per-bit BIT_VLD/BIT_ERR outputs.

Parameters:
- CW, 32, width of BIT_CNT and ERR_CNT result counters
- GW, 16, width of gate-length down-counter (GATE_LEN)
- SW, 8, width of settle-time down-counter (SETTLE_LEN)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- START  in  1  begin measurement; accepted only when BUSY=0
- STOP  in  1  end free-run measurement; honoured only in MEASURE
- ABORT  in  1  cancel measurement, no DONE
- SETTLE_LEN  in  SW  settle cycles, sampled on accepted START
- GATE_LEN  in  GW  window length in valid bits, sampled on START; 0 = free-run
- SYNC_OK  in  1  checker pattern lock
- BIT_VLD  in  1  one compared bit this cycle
- BIT_ERR  in  1  that bit mismatched; qualified by BIT_VLD
- BUSY  out  1  high in SETTLE and MEASURE
- DONE  out  1  one-cycle pulse at normal completion
- BIT_CNT  out  CW  valid bits counted in current/last window
- ERR_CNT  out  CW  errors counted in current/last window
- CNT_SAT  out  1  sticky: BIT_CNT or ERR_CNT saturated
- SYNC_LOST  out  1  sticky: SYNC_OK low at any MEASURE cycle

Behaviour:
- Reset (RST=1 at an edge): state IDLE; all outputs 0; internal counters 0. Reset has priority over every input.
- States: IDLE, SETTLE, MEASURE, FIN. All outputs are registered.
- IDLE/FIN, START=1, ABORT=0:
  - Load settle counter with SETTLE_LEN and gate counter with GATE_LEN.
  - Latch free-run mode = (GATE_LEN==0).
  - Clear BIT_CNT, ERR_CNT, CNT_SAT, SYNC_LOST.
  - Next state SETTLE, so BUSY is high the cycle after START.
- SETTLE:
  - Settle counter decrements each cycle while nonzero.
  - When counter==0 and SYNC_OK=1, next state is MEASURE.
  - Exits no earlier than SETTLE_LEN+1 cycles after entry.
  - SETTLE_LEN=0 exits on the first SYNC_OK cycle.
  - Waits indefinitely for SYNC_OK.
  - BIT_VLD ignored; STOP ignored.
- MEASURE, on each BIT_VLD=1 cycle:
  - BIT_CNT += 1.
  - ERR_CNT += BIT_ERR.
  - Gate counter decrements (not in free-run).
  - BIT_ERR with BIT_VLD=0 is ignored.
- Saturation: BIT_CNT and ERR_CNT saturate at all-ones, never wrap. Any saturation sets CNT_SAT, which stays set until the next accepted START.
- SYNC_LOST set in any MEASURE cycle with SYNC_OK=0. Counting continues.
- Gated end: BIT_VLD with gate counter==1 counts that bit, then next state FIN. Exactly GATE_LEN bits are counted.
- Free-run end: STOP=1 in MEASURE goes to FIN. A BIT_VLD in the same cycle is still counted.
- STOP and last gated bit in the same cycle give a single FIN.
- FIN: lasts one cycle; DONE=1; BUSY=0. Next state IDLE, or SETTLE if START=1.
- Results hold in IDLE until the next accepted START.
- ABORT=1 in any state: next state IDLE; DONE not asserted; counts hold their current values. ABORT beats START and STOP in the same cycle.
- START while BUSY=1 is ignored. SETTLE_LEN/GATE_LEN changes mid-measurement have no effect.

Decomposition:
- Shared include/package ber_pkg:
  - state encodings ST_IDLE, ST_SETTLE, ST_MEASURE, ST_FIN (2-bit localparams);
  - default CW/GW/SW.
- One sub-module: ber_dcnt, a parameterised down-counter.
  - Synchronous active-high reset, LOAD/VAL, DEC, zero flag.
  - Instantiated twice, for settle (SW) and gate (GW).
- Saturating increment stays inline.

Test Plan:
1. Basic gated window: START at cycle 0 with SETTLE_LEN=3, GATE_LEN=10, SYNC_OK=1, BIT_VLD every cycle, BIT_ERR on 2 bits.
   -> BUSY from cycle 1; MEASURE cycles 5-14; DONE at cycle 15 only; BIT_CNT=10, ERR_CNT=2, CNT_SAT=0, SYNC_LOST=0.
2. Lock wait: SETTLE_LEN=0, SYNC_OK low for 20 cycles after START, then high; GATE_LEN=4.
   -> Stays in SETTLE; MEASURE starts the cycle after SYNC_OK rises; BIT_VLD before that is not counted.
3. Sparse data: BIT_VLD every 3rd cycle, BIT_ERR also toggling on invalid cycles, GATE_LEN=4.
   -> DONE the cycle after the 4th valid bit; ERR_CNT counts only qualified errors.
4. Free-run saturation: CW=4, GATE_LEN=0, 20 valid errored bits, then STOP.
   -> BIT_CNT=15, ERR_CNT=15, CNT_SAT=1, one DONE pulse; STOP during SETTLE ignored.
5. ABORT with START and STOP in the same cycle at MEASURE bit 6 of 10.
   -> IDLE next cycle; no DONE; BIT_CNT holds 6. A following START is accepted and clears counts.
6. RST for 1 cycle mid-MEASURE, SYNC_OK dropped 2 cycles earlier.
   -> All outputs 0, IDLE. A new run with SYNC_OK low for 1 MEASURE cycle ends with SYNC_LOST=1 and a full count.
